user_int8_seq: RTL
==================

Name: user_int8_seq

Overview:
- OBI manager sequencer in the user domain; drives the user manager port (`user_mgr_obi_req_o` / `user_mgr_obi_rsp_i`).
- Streams operand pairs from memory into the int8 compute unit and writes each result back to memory.
- Upstream feeder of the int8 unit. Configured by user register outputs; replaces the tied-off manager request.

Parameters:
- ComputeLatency, 1, cycles from operands valid to `result_i` valid (1..15).
- MaxLen, 1024, maximum word count accepted; larger `len_i` saturates to MaxLen.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle start pulse
- func_i  in  32  function word, passed through to the compute unit
- src_a_addr_i  in  32  base byte address of operand-A array (word aligned)
- src_b_addr_i  in  32  base byte address of operand-B array
- dst_addr_i  in  32  base byte address of result array
- len_i  in  32  number of words to process
- obi_req_o  out  mgr_obi_req_t  OBI manager request
- obi_rsp_i  in  mgr_obi_rsp_t  OBI manager response
- func_o  out  32  func to compute unit
- a_o  out  32  operand A to compute unit
- b_o  out  32  operand B to compute unit
- result_i  in  32  result from compute unit
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse at end of job
- err_o  out  1  sticky: last job hit an OBI error; cleared by next accepted start

Behaviour:
- Reset values:
  - `obi_req_o` all zero (req=0, we=0, be=0, addr=0, wdata=0).
  - `a_o`, `b_o`, `func_o` = 0; `busy_o`, `done_o`, `err_o` = 0.
  - FSM in IDLE; counters = 0.
- Reset mid-operation: immediate return to IDLE with the outputs above. No completion of an outstanding transaction; the response is ignored after reset.
- FSM states:
  - IDLE
  - RD_A: req a-addr, then wait rvalid
  - RD_B: same for B
  - COMP
  - WR: req, then wait rvalid
  - FIN
- IDLE:
  - start_i=1 latches func, addresses, and len (saturated to MaxLen).
  - Clears `err_o`, sets `busy_o`.
  - Goes to RD_A if len≠0, else to FIN.
  - start_i while busy is ignored.
- OBI handshake:
  - At most one outstanding transaction.
  - `req` held high with stable `addr`/`we`/`be`/`wdata` until the cycle `gnt`=1; `req` drops the next cycle.
  - Response accepted on `rvalid`; `rready` is tied 1.
  - `be` = 4'hF for all accesses.
- RD_A: read at `src_a + 4*i`; on rvalid, `a_o` <= rdata. RD_B does the same into `b_o`.
- COMP: counts ComputeLatency cycles from `b_o` update, then samples `result_i` into the write-data register.
- WR: write at `dst + 4*i`; on rvalid, i++. If i==len go to FIN, else go to RD_A.
- Error: rvalid with err=1 in any state sets `err_o` and goes to FIN. No further requests are issued.
- FIN: `done_o`=1 for one cycle, `busy_o` drops in the same cycle, then IDLE.
- Address arithmetic: 32-bit wrap-around, no check. Index counter is clog2(MaxLen+1) bits.
- Throughput: minimum per word = 3 OBI transactions + ComputeLatency + 3 cycles.
- `a_o`, `b_o`, `func_o` hold their values between jobs.

Optional Feature:
- Macro USER_INT8_SEQ_IRQ_EN.
- Defined: adds port `irq_o` (out, 1) and `irq_clr_i` (in, 1).
  - `irq_o` is set the cycle after `done_o`.
  - Held until `irq_clr_i`=1; clear wins over a simultaneous set.
  - Reset value 0.
- Undefined: ports absent; no interrupt logic.

Test Plan:
- Basic job: len=4, src_a=0x1000 {1,2,3,4}, src_b=0x2000 {5,6,7,8}, compute model a+b, ComputeLatency=1 -> memory 0x3000 = {6,8,10,12}; one `done_o` pulse; `err_o`=0.
- Zero length: start with len=0 -> no `obi_req_o.req` asserted; `done_o` exactly 2 cycles after start; `busy_o` high for 1 cycle.
- Grant stall: slave holds gnt=0 for 5 cycles on each request -> `req`/`addr` stable throughout; results identical to the basic job.
- Error abort: len=4, error response on 2nd read of B (addr 0x2004) -> `err_o`=1, `done_o` pulse, no write to 0x3004; next start clears `err_o`.
- Reset mid-job: assert rst_i during WR of word 1 -> `obi_req_o.req`=0 and `busy_o`=0 same cycle; after release, a new start runs correctly.
- Start while busy: second start pulse during RD_B -> ignored; only one `done_o`; with USER_INT8_SEQ_IRQ_EN, `irq_o`=1 until `irq_clr_i`.

Source files
------------

// File: rtl/user_int8_seq.sv
// user_int8_seq: OBI manager sequencer that streams operand pairs from memory
// into the int8 compute unit and writes each result back to memory.
// For every word i: read A[i], read B[i], wait ComputeLatency cycles, write
// result to DST[i]. At most one OBI transaction is outstanding at any time.
// Optional interrupt output is enabled by defining USER_INT8_SEQ_IRQ_EN.

package user_int8_seq_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mgr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_rsp_t;
endpackage

module user_int8_seq
  import user_int8_seq_pkg::*;
#(
  parameter int ComputeLatency = 1,
  parameter int MaxLen         = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [31:0]  func_i,
  input  logic [31:0]  src_a_addr_i,
  input  logic [31:0]  src_b_addr_i,
  input  logic [31:0]  dst_addr_i,
  input  logic [31:0]  len_i,
  output mgr_obi_req_t obi_req_o,
  input  mgr_obi_rsp_t obi_rsp_i,
  output logic [31:0]  func_o,
  output logic [31:0]  a_o,
  output logic [31:0]  b_o,
  input  logic [31:0]  result_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [2:0]   dbg_state_o
`ifdef USER_INT8_SEQ_IRQ_EN
  ,
  output logic         irq_o,
  input  logic         irq_clr_i
`endif
);

  localparam int IW = $clog2(MaxLen + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_COMP = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Handshake: a request is presented with r_req=1 and stays stable until the
  // cycle gnt=1; the transaction is then outstanding (r_wait=1) until rvalid.
  // The manager always accepts responses, so rready is implicitly 1.
  state_t          r_state;
  state_t          w_next;
  logic            r_req;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_wait;
  logic [31:0]     r_func;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_a_base;
  logic [31:0]     r_b_base;
  logic [31:0]     r_d_base;
  logic [IW-1:0]   r_len;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_gnt;
  logic            w_rsp;
  logic [IW-1:0]   w_len_sat;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_last;
  logic            w_comp_done;
  logic [31:0]     w_off;
  logic [31:0]     w_off_nxt;

  assign w_gnt       = r_req & obi_rsp_i.gnt;
  assign w_rsp       = r_wait & obi_rsp_i.rvalid;
  assign w_len_sat   = (len_i > 32'(MaxLen)) ? IW'(MaxLen) : len_i[IW-1:0];
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last      = (w_idx_nxt == r_len);
  assign w_comp_done = (r_cnt == 4'(ComputeLatency));
  assign w_off       = {{(30-IW){1'b0}}, r_idx, 2'b00};
  assign w_off_nxt   = {{(30-IW){1'b0}}, w_idx_nxt, 2'b00};

  assign obi_req_o.req   = r_req;
  assign obi_req_o.we    = r_we;
  assign obi_req_o.be    = r_req ? 4'hF : 4'h0;
  assign obi_req_o.addr  = r_addr;
  assign obi_req_o.wdata = r_wdata;

  assign func_o      = r_func;
  assign a_o         = r_a;
  assign b_o         = r_b;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = (w_len_sat == '0) ? S_FIN : S_RD_A;
      S_RD_A: if (w_rsp) w_next = obi_rsp_i.err ? S_FIN : S_RD_B;
      S_RD_B: if (w_rsp) w_next = obi_rsp_i.err ? S_FIN : S_COMP;
      S_COMP: if (w_comp_done) w_next = S_WR;
      S_WR:   if (w_rsp) w_next = (obi_rsp_i.err || w_last) ? S_FIN : S_RD_A;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: job registers, OBI request issue and response capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wait   <= 1'b0;
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_d_base <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_gnt) begin
        r_req  <= 1'b0;
        r_wait <= 1'b1;
      end
      if (w_rsp) r_wait <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_func   <= func_i;
            r_a_base <= src_a_addr_i;
            r_b_base <= src_b_addr_i;
            r_d_base <= dst_addr_i;
            r_len    <= w_len_sat;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            if (w_len_sat != '0) begin
              r_req  <= 1'b1;
              r_we   <= 1'b0;
              r_addr <= src_a_addr_i;
            end
          end
        end
        S_RD_A: begin
          if (w_rsp) begin
            if (obi_rsp_i.err) r_err <= 1'b1;
            else begin
              r_a    <= obi_rsp_i.rdata;
              r_req  <= 1'b1;
              r_we   <= 1'b0;
              r_addr <= r_b_base + w_off;
            end
          end
        end
        S_RD_B: begin
          if (w_rsp) begin
            if (obi_rsp_i.err) r_err <= 1'b1;
            else begin
              r_b   <= obi_rsp_i.rdata;
              r_cnt <= '0;
            end
          end
        end
        S_COMP: begin
          // Operands became valid on entry; result is valid ComputeLatency later.
          r_cnt <= r_cnt + 1'b1;
          if (w_comp_done) begin
            r_wdata <= result_i;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= r_d_base + w_off;
          end
        end
        S_WR: begin
          if (w_rsp) begin
            if (obi_rsp_i.err) r_err <= 1'b1;
            else begin
              r_idx <= w_idx_nxt;
              if (!w_last) begin
                r_req  <= 1'b1;
                r_we   <= 1'b0;
                r_addr <= r_a_base + w_off_nxt;
              end
            end
          end
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef USER_INT8_SEQ_IRQ_EN
  logic r_irq;
  assign irq_o = r_irq;

  // Interrupt flag: set the cycle after done, clear has priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_irq <= 1'b0;
    else if (irq_clr_i) r_irq <= 1'b0;
    else if (r_done)    r_irq <= 1'b1;
  end
`endif

endmodule
